// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester, memory and status signals of dm_arbiter (err exists only with DM_ARB_ERR_EN)
interface dm_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_wdata;
  logic [3:0]        ext_be;
  logic [31:0]       ext_rdata;
  logic              ext_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

`ifdef DM_ARB_ERR_EN
  logic              err;
`endif
  logic              busy;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ready,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_be,
    output ext_rdata, ext_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata,
`ifdef DM_ARB_ERR_EN
    output err,
`endif
    output busy
  );

  // Environment side: both requesters plus the data memory
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ready,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_be,
    input  ext_rdata, ext_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata,
`ifdef DM_ARB_ERR_EN
    input  err,
`endif
    input  busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU-priority data-memory arbiter with starvation guard (optional DM_ARB_ERR_EN: illegal byte-enable rejection)
module dm_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt;
  logic              cmd_ext;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_be;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       ext_rdata_q;
  logic              any_req;
  logic              grant_ext;
  logic              be_ok;
  logic              access_en;
  logic              resp_cyc;

  // CPU wins unless only ext asks or ext has lost STARVE_LIMIT times in a row
  always_comb begin
    any_req   = bus.cpu_req | bus.ext_req;
    grant_ext = bus.ext_req & (~bus.cpu_req | (starve_cnt == LIMIT));
  end

`ifdef DM_ARB_ERR_EN
  // Only naturally aligned byte, half and word enables reach memory
  always_comb begin
    case (cmd_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end
`else
  assign be_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-phase strobes
  always_comb begin
    state_nxt = state;
    access_en = 1'b0;
    resp_cyc  = 1'b0;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  begin
        access_en = be_ok;
        state_nxt = RESP;
      end
      RESP:    begin
        resp_cyc  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture and starvation count, sampled only when arbitrating in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ext    <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_be     <= '0;
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      cmd_ext   <= grant_ext;
      cmd_we    <= grant_ext ? bus.ext_we    : bus.cpu_we;
      cmd_addr  <= grant_ext ? bus.ext_addr  : bus.cpu_addr;
      cmd_wdata <= grant_ext ? bus.ext_wdata : bus.cpu_wdata;
      cmd_be    <= grant_ext ? bus.ext_be    : bus.cpu_be;
      if (grant_ext)
        starve_cnt <= '0;
      else if (bus.ext_req && starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Read data lands in the winner's register at the edge closing ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else if (access_en && !cmd_we) begin
      if (cmd_ext) ext_rdata_q <= bus.mem_rdata;
      else         cpu_rdata_q <= bus.mem_rdata;
    end
  end

  // mem_en is gated by reset so a reset landing mid-ACCESS commits nothing
  assign bus.mem_en    = access_en & ~reset;
  assign bus.mem_we    = access_en & ~reset & cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.mem_be    = cmd_be;

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.cpu_ready = resp_cyc & ~cmd_ext & ~reset;
  assign bus.ext_ready = resp_cyc &  cmd_ext & ~reset;
  assign bus.busy      = (state != IDLE);

`ifdef DM_ARB_ERR_EN
  assign bus.err = resp_cyc & ~be_ok & ~reset;
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter (vector table, corner sequences, randomized model check)
module tb_dm_arbiter;
  localparam int STARVE_LIMIT = 3;
  localparam int ADDR_W       = 32;
  localparam int RAND_CYC     = 400;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;

  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dm_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural data memory: combinational read, byte-enabled write on the clock
  logic [31:0] dm [0:255];
  assign bus.mem_rdata = dm[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) dm[i] <= 32'h0;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) dm[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit is_ext, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (is_ext) begin
      bus.ext_req = req; bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata; bus.ext_be = be;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_be = be;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
    chk({tag, "_mem_en"},    32'(bus.mem_en),    32'h0);
    chk({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'h0);
    chk({tag, "_ext_ready"}, 32'(bus.ext_ready), 32'h0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata,      32'h0);
    chk({tag, "_ext_rdata"}, bus.ext_rdata,      32'h0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'h0);
    chk({tag, "_mem_be"},    32'(bus.mem_be),    32'h0);
`ifdef DM_ARB_ERR_EN
    chk({tag, "_err"},       32'(bus.err),       32'h0);
`endif
  endtask

  typedef struct {
    bit          is_ext;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          exp_en;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(bit e, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                              int en, logic [31:0] rd, bit er);
    vec_t v;
    v.is_ext = e; v.we = we; v.addr = a; v.wdata = wd; v.be = be;
    v.exp_en = en; v.exp_rdata = rd; v.exp_err = er;
    return v;
  endfunction

  // One isolated transaction: ready two cycles after the sampling edge, one mem_en cycle
  task automatic run_one(input vec_t v, input int idx);
    int   cyc = 0;
    int   en_cnt = 0;
    int   other = 0;
    bit   got = 1'b0;
    logic [31:0] rd = 32'h0;
    logic        er = 1'b0;
    @(negedge clk);
    drive(v.is_ext, 1'b1, v.we, v.addr, v.wdata, v.be);
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_en) en_cnt++;
      if (v.is_ext ? bus.cpu_ready : bus.ext_ready) other++;
      if (v.is_ext ? bus.ext_ready : bus.cpu_ready) begin
        got = 1'b1;
        rd  = v.is_ext ? bus.ext_rdata : bus.cpu_rdata;
`ifdef DM_ARB_ERR_EN
        er  = bus.err;
`endif
      end
    end
    if (v.is_ext) bus.ext_req = 1'b0;
    else          bus.cpu_req = 1'b0;
    chk($sformatf("vec%0d_ready_latency", idx), 32'(cyc), 32'd2);
    chk($sformatf("vec%0d_mem_en_cycles", idx), 32'(en_cnt), 32'(v.exp_en));
    chk($sformatf("vec%0d_other_ready", idx), 32'(other), 32'd0);
    if (!v.we) chk($sformatf("vec%0d_rdata", idx), rd, v.exp_rdata);
`ifdef DM_ARB_ERR_EN
    chk($sformatf("vec%0d_err", idx), 32'(er), 32'(v.exp_err));
`endif
  endtask

  // Random-phase reference state: a transaction-level view of the arbiter
  logic [31:0] ref_mem [0:255];
  logic [3:0]  legal_be [0:6];

  initial begin
    vec_t vt[$];
    bit   exp_order [8];
    bit   got_order [8];
    int   grants;
    int   cnt;
    int   cyc;
    int   first_en, second_en, rdy_n;
    logic second_we;
    logic [31:0] rd;

    legal_be[0] = 4'b0001; legal_be[1] = 4'b0010; legal_be[2] = 4'b0100; legal_be[3] = 4'b1000;
    legal_be[4] = 4'b0011; legal_be[5] = 4'b1100; legal_be[6] = 4'b1111;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    mem_clear = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mem_clear = 1'b0;
    @(negedge clk);
    chk_reset("por");

    // ---- vector table ----
    vt.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 1, 32'h0, 0));
    vt.push_back(mk(0, 0, 32'h10, 32'h0,        4'b1111, 1, 32'hDEADBEEF, 0));
    vt.push_back(mk(1, 1, 32'h10, 32'h00AA0000, 4'b0100, 1, 32'h0, 0));
    vt.push_back(mk(0, 0, 32'h10, 32'h0,        4'b1111, 1, 32'hDEAABEEF, 0));
    vt.push_back(mk(1, 0, 32'h10, 32'h0,        4'b1111, 1, 32'hDEAABEEF, 0));
    vt.push_back(mk(0, 1, 32'h20, 32'hCAFEF00D, 4'b1111, 1, 32'h0, 0));
    vt.push_back(mk(1, 1, 32'h30, 32'h11223344, 4'b1111, 1, 32'h0, 0));
    vt.push_back(mk(0, 1, 32'h30, 32'h00005500, 4'b0010, 1, 32'h0, 0));
    vt.push_back(mk(1, 0, 32'h30, 32'h0,        4'b1111, 1, 32'h11225544, 0));
`ifdef DM_ARB_ERR_EN
    vt.push_back(mk(1, 1, 32'h30, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1));
    vt.push_back(mk(0, 0, 32'h30, 32'h0,        4'b1111, 1, 32'h11225544, 0));
`else
    vt.push_back(mk(1, 1, 32'h30, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 0));
    vt.push_back(mk(0, 0, 32'h30, 32'h0,        4'b1111, 1, 32'h11BB55DD, 0));
`endif
    vt.push_back(mk(0, 1, 32'h34, 32'h98760000, 4'b1100, 1, 32'h0, 0));
    vt.push_back(mk(1, 0, 32'h34, 32'h0,        4'b1111, 1, 32'h98760000, 0));
    foreach (vt[i]) run_one(vt[i], i);

    // ---- reset during ACCESS of a CPU write ----
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    @(negedge clk);
    chk("rst_in_access_mem_en", 32'(bus.mem_en), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_gates_mem_en", 32'(bus.mem_en), 32'h0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_reset("rst_mid");
    rdy_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.cpu_ready || bus.ext_ready) rdy_n++;
    end
    chk("rst_no_ready", 32'(rdy_n), 32'h0);
    chk("rst_no_commit", dm[8], 32'hCAFEF00D);

    // ---- contention: both requesters held with back-to-back commands ----
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h200, 32'hC0000000, 4'b1111);
    drive(1'b1, 1'b1, 1'b1, 32'h280, 32'hE0000000, 4'b1111);
    grants = 0;
    cyc = 0;
    while (grants < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ready) begin
        got_order[grants] = 1'b0;
        grants++;
        drive(1'b0, 1'b1, 1'b1, 32'h200 + 32'(4 * grants), 32'hC0000000 + 32'(grants), 4'b1111);
      end
      if (bus.ext_ready) begin
        got_order[grants] = 1'b1;
        grants++;
        chk("starve_clear_after_ext", 32'(dut.starve_cnt), 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h280 + 32'(4 * grants), 32'hE0000000 + 32'(grants), 4'b1111);
      end
    end
    bus.ext_req = 1'b0;
    chk("contention_grants", 32'(grants), 32'd8);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_order[i] = (cnt == STARVE_LIMIT);
      cnt = exp_order[i] ? 0 : cnt + 1;
      chk($sformatf("grant%0d_is_ext", i), 32'(got_order[i]), 32'(exp_order[i]));
    end
    cyc = 0;
    while (!bus.cpu_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // ---- held request: write then a new read without dropping req ----
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D, 4'b1111);
    first_en = -1; second_en = -1; second_we = 1'b1; rdy_n = 0; rd = 32'h0;
    for (int c = 1; c <= 12 && rdy_n < 2; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (first_en < 0) first_en = c;
        else begin second_en = c; second_we = bus.mem_we; end
      end
      if (bus.cpu_ready) begin
        rdy_n++;
        if (rdy_n == 1) drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'b1111);
        else begin rd = bus.cpu_rdata; bus.cpu_req = 1'b0; end
      end
    end
    bus.cpu_req = 1'b0;
    chk("held_ready_count", 32'(rdy_n), 32'd2);
    chk("held_access_spacing", 32'(second_en - first_en), 32'd3);
    chk("held_second_is_read", 32'(second_we), 32'h0);
    chk("held_read_data", rd, 32'h0BADF00D);
    repeat (2) @(negedge clk);

    // ---- randomized traffic against a transaction-level model ----
    begin
      bit          c_act = 0, e_act = 0;
      logic        c_we = 0, e_we = 0;
      logic [31:0] c_a = 0, e_a = 0, c_d = 0, e_d = 0;
      logic [3:0]  c_b = 0, e_b = 0;
      int          g_cyc = -10;
      int          free_at = 0;
      int          starve = 0;
      bit          g_ext = 0, g_read = 0;
      logic [31:0] g_rdata = 0;
      bit          c_done, e_done, win_ext;
      logic [31:0] wa, wd;
      logic [3:0]  wb;
      logic        ww;
      for (int t = 0; t < RAND_CYC + 30; t++) begin
        @(negedge clk);
        c_done = (t == g_cyc + 2) && !g_ext;
        e_done = (t == g_cyc + 2) &&  g_ext;
        chk("rnd_mem_en",    32'(bus.mem_en),    32'(t == g_cyc + 1));
        chk("rnd_cpu_ready", 32'(bus.cpu_ready), 32'(c_done));
        chk("rnd_ext_ready", 32'(bus.ext_ready), 32'(e_done));
        if (c_done && g_read) chk("rnd_cpu_rdata", bus.cpu_rdata, g_rdata);
        if (e_done && g_read) chk("rnd_ext_rdata", bus.ext_rdata, g_rdata);
`ifdef DM_ARB_ERR_EN
        chk("rnd_err", 32'(bus.err), 32'h0);
`endif
        if (c_done) c_act = 1'b0;
        if (e_done) e_act = 1'b0;
        if (!c_act && t < RAND_CYC && $urandom_range(0, 2) != 0) begin
          c_act = 1'b1; c_we = 1'($urandom_range(0, 1)); c_a = 32'h100 + 32'(4 * $urandom_range(0, 15));
          c_d = $urandom; c_b = legal_be[$urandom_range(0, 6)];
        end
        if (!e_act && t < RAND_CYC && $urandom_range(0, 2) != 0) begin
          e_act = 1'b1; e_we = 1'($urandom_range(0, 1)); e_a = 32'h100 + 32'(4 * $urandom_range(0, 15));
          e_d = $urandom; e_b = legal_be[$urandom_range(0, 6)];
        end
        drive(1'b0, c_act, c_we, c_a, c_d, c_b);
        drive(1'b1, e_act, e_we, e_a, e_d, e_b);
        if (t >= free_at && (c_act || e_act)) begin
          win_ext = e_act && (!c_act || starve == STARVE_LIMIT);
          if (win_ext) starve = 0;
          else if (e_act) starve++;
          ww = win_ext ? e_we : c_we;
          wa = win_ext ? e_a : c_a;
          wd = win_ext ? e_d : c_d;
          wb = win_ext ? e_b : c_b;
          g_cyc = t; free_at = t + 3; g_ext = win_ext; g_read = !ww;
          if (ww) begin
            for (int b = 0; b < 4; b++)
              if (wb[b]) ref_mem[wa[9:2]][b*8 +: 8] = wd[b*8 +: 8];
          end else begin
            g_rdata = ref_mem[wa[9:2]];
          end
        end
      end
      for (int w = 64; w < 80; w++) chk($sformatf("rnd_final_mem[%0d]", w), dm[w], ref_mem[w]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port, byte-enabled data memory between two requesters: the CPU MEM-stage data port and an external port used for debug/DMA preload.
- Sits directly in front of the data memory and owns its en/we/addr/wdata/be bus.
- The CPU port has priority. A starvation counter guarantees the external port forward progress.
- Each granted access is sequenced through a 3-state FSM with a registered read-data return and a one-cycle ready pulse.

Parameters:
- STARVE_LIMIT, 3: consecutive CPU wins against a pending ext_req, after which ext wins the next arbitration. Legal range 1..15.
- ADDR_W, 32: address width on all ports.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU request; held with command stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  write data, already lane-aligned
- cpu_be  in  4  byte enables
- cpu_rdata  out  32  registered read word (full word; the requester extracts the byte/half)
- cpu_ready  out  1  one-cycle completion pulse
- ext_req, ext_we, ext_addr, ext_wdata, ext_be  in  same widths as the cpu_* inputs  external port command
- ext_rdata  out  32  registered read word for the external port
- ext_ready  out  1  one-cycle completion pulse for the external port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  32  write data to memory
- mem_be  out  4  byte enables to memory
- mem_rdata  in  32  combinational read word from memory at mem_addr
- busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. All transitions occur on posedge clk.
- IDLE:
  - If either req is high, latch the winner ID plus its we/addr/wdata/be into command registers, then go to ACCESS.
  - If neither req is high, stay in IDLE.
- Arbitration (evaluated in IDLE only):
  - Only cpu_req high: CPU wins.
  - Only ext_req high: ext wins.
  - Both high: ext wins if starve_cnt == STARVE_LIMIT, else CPU wins.
- starve_cnt (4-bit):
  - Increments when CPU wins while ext_req is high.
  - Clears when ext wins.
  - Holds otherwise; never exceeds STARVE_LIMIT.
- ACCESS:
  - mem_en = 1; mem_we/addr/wdata/be driven from the command registers.
  - DM commits a write at the closing edge of ACCESS.
  - On a read, mem_rdata is captured into the winner's rdata register at that same edge. On a write, rdata registers hold their value.
  - Next state RESP.
- RESP:
  - The winner's ready = 1 for exactly this cycle; the loser's ready stays 0.
  - mem_en = 0. Next state IDLE.
- Outside ACCESS:
  - mem_en = 0 and mem_we = 0.
  - mem_addr/wdata/be hold the last command (no toggling).
- Latency: request seen in IDLE at edge N -> ready high in cycle N+2 -> earliest next arbitration at edge N+3. Peak throughput is one access per 3 cycles.
- Requester rules:
  - Command must be held stable from req assertion until ready.
  - At the edge ending the ready cycle, the requester either drops req or presents a new command. A req held high re-arbitrates as a new transaction.
- Simultaneous new requests in IDLE are resolved only by the arbitration rule above. The losing request stays pending, with no timeout.
- Command registers are not sampled outside IDLE, so input changes during ACCESS/RESP do not affect the transaction in flight.
- Reset:
  - Values after reset: state = IDLE, starve_cnt = 0, cpu_ready = ext_ready = 0, cpu_rdata = ext_rdata = 0, command registers 0, busy = 0.
  - mem_en is gated by !reset combinationally, so a reset asserted during ACCESS commits no write.
  - Any in-flight transaction is dropped with no ready pulse.
- Address width: no address checking; the memory uses its own index bits.

Optional Feature:
- Macro: DM_ARB_ERR_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - A command whose be is not one of 0001/0010/0100/1000/0011/1100/1111 skips memory: mem_en stays 0 in ACCESS and the rdata register is unchanged.
  - RESP asserts the winner's ready with err = 1 for that one cycle. err is 0 in every other cycle.
- Undefined:
  - There is no err port.
  - Every be pattern is passed to memory unchanged, including 0000, which still asserts mem_en.

Test Plan:
- CPU write alone: cpu_we = 1, addr = 0x10, wdata = 0xDEADBEEF, be = 1111 -> mem_en high exactly one cycle (ACCESS); cpu_ready pulses 2 cycles after req sampled; a subsequent CPU read of 0x10 returns cpu_rdata = 0xDEADBEEF.
- Byte lane write: after 0x10 = 0xDEADBEEF, ext write be = 0100, wdata = 0x00AA0000 -> CPU read of 0x10 returns 0xDEAABEEF; ext_ready pulses, cpu_ready stays 0.
- Contention with STARVE_LIMIT = 3: both reqs held high continuously with back-to-back commands -> grant order CPU, CPU, CPU, EXT, CPU, CPU, CPU, EXT; starve_cnt reads 0 after each EXT grant.
- Reset during ACCESS of CPU write 0x20 = 0x12345678 -> no commit (DM word at 0x20 unchanged); cpu_ready never pulses; state = IDLE and all outputs at reset values on the next cycle.
- Held request: cpu_req kept high across ready with a new command (read 0x10) -> a second distinct access starts 3 cycles after the first ACCESS, not a duplicate write.
- DM_ARB_ERR_EN defined, ext write be = 0101 -> mem_en stays 0, ext_ready = 1 and err = 1 in the same cycle, memory unchanged. With the macro undefined, the same command writes lanes 0 and 2.
